// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
// Forwarding-select and hazard-detection unit beside the ID stage.
//  - Chooses a forwarding source for every ALU operand (nearest stage wins).
//  - Detects load-use hazards and hazards against one outstanding multi-cycle
//    (MC) operation tracked by a small IDLE/BUSY/DONE scoreboard.
//  - Raises stall/bubble_ex until the producing result is available.
//
// Ports
//  clk, rst            : rising-edge clock, synchronous active-high reset
//  rs_id/rs_used_id    : ID source addresses (packed per source) and valids
//  rd_id/regwrite_id   : ID destination and its write enable
//  mc_op_id            : ID instruction is an MC op
//  rd_stage/regwrite_stage : destination/write enable per forwarding stage
//  memread_ex          : stage 0 holds a load
//  mc_issue_ex/mc_rd_ex: MC op issuing from EX and its destination
//  fwd_sel             : per source, 0 = register file, k = stage k-1
//  stall/bubble_ex     : combinational hazard outputs
//  mc_busy/mc_done/mc_rd/mc_err : scoreboard status
//  stall_cnt           : saturating stall-cycle counter
//
// Build option: define FWD_HAZARD_STALL_CNT_EN to enable stall_cnt;
// otherwise stall_cnt is tied to zero.

module fwd_hazard_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned MC_LAT     = 4,
  parameter int unsigned SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   rs_id,
  input  logic [NUM_SRC-1:0]              rs_used_id,
  input  logic [REG_ADDR_W-1:0]           rd_id,
  input  logic                            regwrite_id,
  input  logic                            mc_op_id,
  input  logic [FWD_DEPTH*REG_ADDR_W-1:0] rd_stage,
  input  logic [FWD_DEPTH-1:0]            regwrite_stage,
  input  logic                            memread_ex,
  input  logic                            mc_issue_ex,
  input  logic [REG_ADDR_W-1:0]           mc_rd_ex,
  output logic [NUM_SRC*SEL_W-1:0]        fwd_sel,
  output logic                            stall,
  output logic                            bubble_ex,
  output logic                            mc_busy,
  output logic                            mc_done,
  output logic [REG_ADDR_W-1:0]           mc_rd,
  output logic                            mc_err,
  output logic [31:0]                     stall_cnt
);

  localparam int unsigned CNT_W = $clog2(MC_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0]   mc_rd_q, mc_rd_d;
  logic                    mc_err_q, mc_err_d;

  logic                    trk_busy_v;
  logic                    trk_iss_v;
  logic                    hazard;
  logic                    stall_c;

  // Forwarding select: scan oldest to nearest so the nearest match wins.
  always_comb begin
    logic [REG_ADDR_W-1:0] rs;
    fwd_sel = '0;
    rs      = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      rs = rs_id[i*REG_ADDR_W +: REG_ADDR_W];
      for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
        if (rs_used_id[i] && (rs != '0) && regwrite_stage[k] &&
            (rd_stage[k*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  // A tracked MC destination of x0 never creates a hazard.
  assign trk_busy_v = (state_q != IDLE) && (mc_rd_q != '0);
  assign trk_iss_v  = mc_issue_ex && (mc_rd_ex != '0);

  // Hazard detection: load-use, MC RAW, MC WAW, MC structural.
  always_comb begin
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rd0;
    hazard = 1'b0;
    rs     = '0;
    rd0    = rd_stage[REG_ADDR_W-1:0];
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      rs = rs_id[i*REG_ADDR_W +: REG_ADDR_W];
      if (rs_used_id[i]) begin
        if (memread_ex && regwrite_stage[0] && (rd0 != '0) && (rs == rd0)) begin
          hazard = 1'b1;
        end
        if (trk_busy_v && (rs == mc_rd_q)) begin
          hazard = 1'b1;
        end
        if (trk_iss_v && (rs == mc_rd_ex)) begin
          hazard = 1'b1;
        end
      end
    end
    if (regwrite_id && ((trk_busy_v && (rd_id == mc_rd_q)) ||
                        (trk_iss_v  && (rd_id == mc_rd_ex)))) begin
      hazard = 1'b1;
    end
    if (mc_op_id && (trk_busy_v || trk_iss_v)) begin
      hazard = 1'b1;
    end
  end

  // Overlapping hazards collapse into one stall; nothing stalls during reset.
  assign stall_c   = hazard && !rst;
  assign stall     = stall_c;
  assign bubble_ex = stall_c;

  // Scoreboard next-state: counter loaded with MC_LAT-1 so BUSY lasts MC_LAT cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_rd_d  = mc_rd_q;
    mc_err_d = mc_err_q;
    if (mc_issue_ex && (state_q != IDLE)) begin
      mc_err_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (mc_issue_ex) begin
          mc_rd_d = mc_rd_ex;
          cnt_d   = CNT_W'(MC_LAT - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mc_rd_q  <= '0;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mc_rd_q  <= mc_rd_d;
      mc_err_q <= mc_err_d;
    end
  end

  assign mc_busy = (state_q != IDLE);
  assign mc_done = (state_q == DONE);
  assign mc_rd   = mc_rd_q;
  assign mc_err  = mc_err_q;

`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard-detection unit for the pipelined core, sitting beside the ID stage. Combinationally selects the forwarding source for each ALU operand across a configurable number of later pipeline stages. Detects load-use hazards and tracks one outstanding multi-cycle (MC) operation with a registered scoreboard state machine. Raises stall/bubble so dependent instructions wait until results are architecturally available.

## Interface
- REG_ADDR_W, 5: register address width.
- NUM_SRC, 2: source operands per instruction.
- FWD_DEPTH, 2: forwarding stages; index 0 = EX/MEM latch (nearest), FWD_DEPTH-1 = oldest.
- MC_LAT, 4: MC execute cycles, ≥1.
- SEL_W, $clog2(FWD_DEPTH+1): width of each select field.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rs_id  in  NUM_SRC*REG_ADDR_W  ID source addresses, source i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- rs_used_id  in  NUM_SRC  per-source valid; an unused source never forwards or stalls.
- rd_id  in  REG_ADDR_W  ID destination.
- regwrite_id  in  1  ID instruction writes rd_id.
- mc_op_id  in  1  ID instruction is an MC op.
- rd_stage  in  FWD_DEPTH*REG_ADDR_W  destination per forwarding stage.
- regwrite_stage  in  FWD_DEPTH  stage writes its rd.
- memread_ex  in  1  stage 0 holds a load.
- mc_issue_ex  in  1  MC op in EX this cycle; its regwrite_stage[0] is driven 0.
- mc_rd_ex  in  REG_ADDR_W  destination of issuing MC op.
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = register file, k = stage k-1.
- stall  out  1  freeze PC and IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- mc_busy  out  1  scoreboard not IDLE.
- mc_done  out  1  one-cycle MC writeback strobe.
- mc_rd  out  REG_ADDR_W  tracked MC destination.
- mc_err  out  1  sticky protocol error.
- stall_cnt  out  32  stall-cycle counter.

## Operation
- Forwarding per source i: lowest k with rs_used_id[i], rs_i≠0, regwrite_stage[k], rd_stage[k]==rs_i → fwd_sel=k+1; else 0. Register 0 never matches.
- Load-use: memread_ex and regwrite_stage[0] and used rs_i==rd_stage[0]≠0 → hazard.
- MC hazards, all when the tracked register is ≠0:
  - RAW: used rs_i matches mc_rd while state≠IDLE, or matches mc_rd_ex while mc_issue_ex.
  - WAW: regwrite_id with rd_id==mc_rd under the same conditions.
  - Structural: mc_op_id while state≠IDLE or mc_issue_ex.
- stall = bubble_ex = OR of all hazards; forced 0 while rst.
- FSM IDLE → BUSY → DONE → IDLE.
  - IDLE & mc_issue_ex: latch mc_rd, load counter MC_LAT-1, go BUSY.
  - BUSY: decrement; at 0 go DONE.
  - DONE: mc_done=1, go IDLE. mc_rd is held until the next issue.
- mc_issue_ex while not IDLE is ignored; it sets mc_err (cleared only by rst).
- Width rules: counter width $clog2(MC_LAT+1). stall_cnt saturates at 2^32-1.

## Timing
- fwd_sel, stall, bubble_ex: combinational, same cycle as inputs.
- Issue sampled at edge ending cycle T. BUSY occupies cycles T+1..T+MC_LAT, DONE is T+MC_LAT+1, IDLE from T+MC_LAT+2.
- A dependent stalls from T through T+MC_LAT+1 and issues at T+MC_LAT+2.
- Load-use stall: exactly one cycle per load.
- Reset values: state IDLE, counter 0, mc_rd 0, mc_busy 0, mc_done 0, mc_err 0, stall_cnt 0.
- Reset mid-operation: the in-flight MC op is abandoned with no mc_done. Outputs take reset values the cycle after rst is sampled.
- Simultaneous hazards: a single stall; a stall is never counted twice.

## Configuration
- FWD_HAZARD_STALL_CNT_EN defined: stall_cnt increments on every cycle with stall=1 and rst=0.
- Not defined: counter logic is absent and stall_cnt is tied to 0.

## Test plan
- rs_id={x3,x3}, both used, regwrite_stage=2'b11, rd_stage={x3,x3} → fwd_sel={1,1}. Same with rd_stage[0]=x0 → {2,2}.
- memread_ex=1, rd_stage[0]=x5, rs_id[0]=x5 used → stall=bubble_ex=1 for one cycle. With rs_used_id[0]=0 → stall=0.
- MC_LAT=4, mc_issue_ex with mc_rd_ex=x7 at cycle 0 → mc_busy cycles 1–5, mc_done at cycle 5. A consumer of x7 stalls cycles 0–5; stall=0 at cycle 6.
- Second mc_issue_ex at cycle 2 → ignored, mc_err=1 sticky, mc_done still at cycle 5. An mc_op_id during busy → stall.
- rst asserted at cycle 3 of an MC op → next cycle mc_busy=0, mc_rd=0, stall_cnt=0, and mc_done never pulses.
- With FWD_HAZARD_STALL_CNT_EN: 3 load-use stalls plus one 6-cycle MC stall → stall_cnt=9. Without the macro → stall_cnt=0.
